// File: rtl/dino_obstacle_ctrl.sv
// Obstacle motion, scoring, speed ramp and collision FSM for the dino runner game.
// Obstacle scrolls left once per frame; each wrap scores a point and every tenth wrap speeds it up.
//   state | meaning
//   IDLE  | waiting for a start press, obstacle/score/speed held at their initial values
//   RUN   | obstacle moves on frame_tick, collision checked every cycle
//   OVER  | collision seen, everything frozen until a restart press
module dino_obstacle_ctrl #(
  parameter int START_X    = 255,
  parameter int DINO_X     = 20,
  parameter int DINO_W     = 16,
  parameter int OBS_W      = 8,
  parameter int OBS_H      = 20,
  parameter int GROUND_Y   = 181,
  parameter int SPEED_INIT = 2,
  parameter int SPEED_MAX  = 8,
  parameter int SCORE_MAX  = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic       frame_tick,
  input  logic [7:0] dinoY,
  output logic [7:0] obstacleX,
  output logic [9:0] score,
  output logic [3:0] speed,
  output logic       running,
  output logic       game_over
);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam logic [7:0] START_X_L    = 8'(START_X);
  localparam logic [3:0] SPEED_INIT_L = 4'(SPEED_INIT);
  localparam logic [3:0] SPEED_MAX_L  = 4'(SPEED_MAX);
  localparam logic [9:0] SCORE_MAX_L  = 10'(SCORE_MAX);
  localparam logic [8:0] DINO_LEFT    = 9'(DINO_X);
  localparam logic [8:0] DINO_RIGHT   = 9'(DINO_X + DINO_W - 1);
  localparam logic [8:0] OBS_W_M1     = 9'(OBS_W - 1);
  localparam logic [8:0] OBS_TOP_Y    = 9'(GROUND_Y - OBS_H);

  state_t     state_q, state_d;
  logic       button_q;
  logic [7:0] obs_x_q, obs_x_d;
  logic [9:0] score_q, score_d;
  logic [3:0] speed_q, speed_d;
  logic [3:0] wrap_cnt_q, wrap_cnt_d;

  logic       btn_rise;
  logic       collision;
  logic [8:0] obs_x9;
  logic [7:0] speed8;

  assign btn_rise = button & ~button_q;
  assign obs_x9   = {1'b0, obs_x_q};
  assign speed8   = {4'b0000, speed_q};

  // 9-bit arithmetic so the obstacle right edge cannot wrap past 255
  assign collision = (obs_x9 <= DINO_RIGHT) &&
                     ((obs_x9 + OBS_W_M1) >= DINO_LEFT) &&
                     ({1'b0, dinoY} > OBS_TOP_Y);

  always_comb begin
    state_d    = state_q;
    obs_x_d    = obs_x_q;
    score_d    = score_q;
    speed_d    = speed_q;
    wrap_cnt_d = wrap_cnt_q;
    case (state_q)
      IDLE: begin
        obs_x_d    = START_X_L;
        score_d    = '0;
        speed_d    = SPEED_INIT_L;
        wrap_cnt_d = '0;
        if (btn_rise) state_d = RUN;
      end
      RUN: begin
        if (collision) begin
          state_d = OVER;
        end else if (frame_tick) begin
          if (obs_x_q >= speed8) begin
            obs_x_d = obs_x_q - speed8;
          end else begin
            obs_x_d = START_X_L;
            score_d = (score_q == SCORE_MAX_L) ? score_q : score_q + 10'd1;
            if (wrap_cnt_q == 4'd9) begin
              wrap_cnt_d = '0;
              speed_d    = (speed_q == SPEED_MAX_L) ? speed_q : speed_q + 4'd1;
            end else begin
              wrap_cnt_d = wrap_cnt_q + 4'd1;
            end
          end
        end
      end
      OVER: begin
        if (btn_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      button_q   <= 1'b0;
      obs_x_q    <= START_X_L;
      score_q    <= '0;
      speed_q    <= SPEED_INIT_L;
      wrap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      button_q   <= button;
      obs_x_q    <= obs_x_d;
      score_q    <= score_d;
      speed_q    <= speed_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign obstacleX = obs_x_q;
  assign score     = score_q;
  assign speed     = speed_q;
  assign running   = (state_q == RUN);
  assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_dino_obstacle_ctrl.sv
// Self-checking bench for dino_obstacle_ctrl: a vector table for reset/start/move,
// then hand-written runs for ground collision, wrap/speed-up, tie, held button and mid-run reset.
module tb_dino_obstacle_ctrl;

  logic       clk = 1'b0;
  logic       rst, button, frame_tick;
  logic [7:0] dinoY;
  logic [7:0] obstacleX;
  logic [9:0] score;
  logic [3:0] speed;
  logic       running, game_over;

  dino_obstacle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .button     (button),
    .frame_tick (frame_tick),
    .dinoY      (dinoY),
    .obstacleX  (obstacleX),
    .score      (score),
    .speed      (speed),
    .running    (running),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [9:0] sc;
    logic [3:0] sp;
    logic       run;
    logic       go;
  } exp_t;

  typedef struct {
    logic       r, b, t;
    logic [7:0] y;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic r, b, t, input logic [7:0] y,
                              input logic [7:0] x, input logic [9:0] sc,
                              input logic [3:0] sp, input logic run, go);
    vec_t v;
    v.r = r; v.b = b; v.t = t; v.y = y;
    v.e.x = x; v.e.sc = sc; v.e.sp = sp; v.e.run = run; v.e.go = go;
    return v;
  endfunction

  task automatic check(input string tag);
    exp_t e;
    e = sb.pop_front();
    n_vec++;
    if (obstacleX !== e.x || score !== e.sc || speed !== e.sp ||
        running !== e.run || game_over !== e.go) begin
      n_bad++;
      $display("FAIL %s @%0t: got x=%0d score=%0d speed=%0d run=%0b over=%0b, want x=%0d score=%0d speed=%0d run=%0b over=%0b",
               tag, $time, obstacleX, score, speed, running, game_over,
               e.x, e.sc, e.sp, e.run, e.go);
    end
  endtask

  task automatic cyc(input logic r, b, t, input logic [7:0] y,
                     input logic [7:0] ex, input logic [9:0] es,
                     input logic [3:0] ep, input logic er, eg, input string tag);
    exp_t e;
    @(negedge clk);
    rst = r; button = b; frame_tick = t; dinoY = y;
    e.x = ex; e.sc = es; e.sp = ep; e.run = er; e.go = eg;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; button = 1'b0; frame_tick = 1'b0; dinoY = 8'd181;

    tbl.push_back(mk(1, 0, 0, 181, 255, 0, 2, 0, 0));
    tbl.push_back(mk(1, 0, 0, 181, 255, 0, 2, 0, 0));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 0, 1, 181, 255, 0, 2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 181, 255, 0, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 181, 255, 0, 2, 1, 0));
    tbl.push_back(mk(0, 0, 1, 181, 253, 0, 2, 1, 0));
    tbl.push_back(mk(0, 0, 1, 181, 251, 0, 2, 1, 0));
    tbl.push_back(mk(0, 0, 1, 181, 249, 0, 2, 1, 0));
    tbl.push_back(mk(0, 0, 1, 181, 247, 0, 2, 1, 0));
    tbl.push_back(mk(0, 0, 1, 181, 245, 0, 2, 1, 0));
    tbl.push_back(mk(0, 1, 0, 181, 245, 0, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 181, 245, 0, 2, 1, 0));

    foreach (tbl[i]) cyc(tbl[i].r, tbl[i].b, tbl[i].t, tbl[i].y, tbl[i].e.x,
                         tbl[i].e.sc, tbl[i].e.sp, tbl[i].e.run, tbl[i].e.go, "table");

    // ground-level dino: obstacle walks in until it overlaps at x=35
    for (int k = 6; k <= 110; k++)
      cyc(0, 0, 1, 181, 8'(255 - 2 * k), 0, 2, 1, 0, "ground_run");
    cyc(0, 0, 0, 181, 35, 0, 2, 0, 1, "ground_over");
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 181, 35, 0, 2, 0, 1, "over_freeze");
    cyc(0, 1, 0, 181, 35, 0, 2, 0, 0, "over_to_idle");
    cyc(0, 0, 0, 181, 255, 0, 2, 0, 0, "idle_reload");
    cyc(0, 1, 0, 151, 255, 0, 2, 1, 0, "restart");
    cyc(0, 0, 0, 151, 255, 0, 2, 1, 0, "restart_hold");

    // jumping dino: ten full wraps, speed steps up on the tenth
    for (int j = 1; j <= 1280; j++) begin
      int i;
      i = ((j - 1) % 128) + 1;
      cyc(0, 0, 1, 151, (i == 128) ? 8'd255 : 8'(255 - 2 * i),
          10'(j / 128), (j >= 1280) ? 4'd3 : 4'd2, 1, 0, "wrap_run");
    end

    for (int k = 1; k <= 74; k++)
      cyc(0, 0, 1, 181, 8'(255 - 3 * k), 10, 3, 1, 0, "fast_run");
    cyc(0, 0, 1, 181, 33, 10, 3, 0, 1, "tie_collision_wins");

    cyc(0, 1, 0, 181, 33, 10, 3, 0, 0, "held_btn_edge");
    for (int k = 1; k < 20; k++) cyc(0, 1, 1, 181, 255, 0, 2, 0, 0, "held_btn_idle");
    cyc(0, 0, 0, 181, 255, 0, 2, 0, 0, "btn_release");
    cyc(0, 1, 0, 181, 255, 0, 2, 1, 0, "run_again");
    cyc(0, 1, 1, 181, 253, 0, 2, 1, 0, "run_again_tick");
    cyc(0, 1, 1, 181, 251, 0, 2, 1, 0, "run_again_tick");
    cyc(1, 0, 1, 181, 255, 0, 2, 0, 0, "rst_mid_run");
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, 181, 255, 0, 2, 0, 0, "post_rst_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
